// File: rtl/noc_lfsr_inject_ctrl.sv
// noc_lfsr_inject_ctrl
// Per-node pseudo-random traffic injector for the 2x2 mesh. A 4-bit XNOR LFSR
// chooses when to inject (lfsr < cfg_rate) and where to send the packet.
// Each packet is PKT_LEN flits, pushed into the local input FIFO over valid/ready.
// Optional backpressure counter: define NOC_INJ_STALL_CNT_EN to build stall_cnt;
// otherwise the stall_cnt port is tied to zero.
module noc_lfsr_inject_ctrl #(
  parameter int MY_ID   = 0,
  parameter int PKT_LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  cfg_rate,
  input  logic        cfg_seed_load,
  input  logic [3:0]  cfg_seed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_flit,
  output logic        busy,
  output logic [15:0] pkt_cnt,
  output logic [3:0]  lfsr_out,
  output logic [15:0] stall_cnt
);

  localparam logic [1:0] MY_ID_B  = 2'(MY_ID);
  localparam logic [3:0] LAST_IDX = 4'(PKT_LEN - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state;
  logic [3:0]  lfsr_q;
  logic [3:0]  flit_idx;
  logic [1:0]  dest_q;
  logic [9:0]  seq_q;
  logic [1:0]  pick_dest;
  logic        fire;

  // Builds one flit; the head carries routing info, later flits carry their index.
  function automatic logic [15:0] make_flit(input logic [3:0] idx,
                                            input logic [1:0] d,
                                            input logic [9:0] s);
    logic [1:0]  ftype;
    logic [15:0] f;
    if (idx == 4'd0)
      ftype = (LAST_IDX == 4'd0) ? 2'b11 : 2'b01;
    else if (idx == LAST_IDX)
      ftype = 2'b10;
    else
      ftype = 2'b00;
    if (idx == 4'd0)
      f = {ftype, d, MY_ID_B, s};
    else
      f = {ftype, idx, s};
    return f;
  endfunction

  // Never target ourselves: a self-destination is mirrored to the diagonal node.
  assign pick_dest = (lfsr_q[3:2] == MY_ID_B) ? (MY_ID_B ^ 2'b11) : lfsr_q[3:2];
  assign fire      = en && (lfsr_q < cfg_rate);

  assign lfsr_out = lfsr_q;
  assign busy     = (state == SEND);

  // LFSR: seed load wins over advance; the all-ones lock-up state is never allowed in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lfsr_q <= 4'h0;
    else if (cfg_seed_load)
      lfsr_q <= (cfg_seed == 4'hF) ? 4'h0 : cfg_seed;
    else if (en)
      lfsr_q <= {lfsr_q[2:0], ~(lfsr_q[3] ^ lfsr_q[0])};
  end

  // Packet sequencer: decide in IDLE, then present flits one at a time until the tail is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_flit  <= 16'h0000;
      flit_idx  <= 4'h0;
      dest_q    <= 2'b00;
      seq_q     <= 10'h000;
      pkt_cnt   <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (fire) begin
            dest_q    <= pick_dest;
            seq_q     <= pkt_cnt[9:0];
            flit_idx  <= 4'h0;
            out_flit  <= make_flit(4'h0, pick_dest, pkt_cnt[9:0]);
            out_valid <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (out_valid && out_ready) begin
            if (flit_idx == LAST_IDX) begin
              out_valid <= 1'b0;
              pkt_cnt   <= pkt_cnt + 16'd1;
              state     <= IDLE;
            end else begin
              flit_idx <= flit_idx + 4'd1;
              out_flit <= make_flit(flit_idx + 4'd1, dest_q, seq_q);
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef NOC_INJ_STALL_CNT_EN
  logic [15:0] stall_q;

  // Counts cycles where a flit is offered but the FIFO is full; saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_q <= 16'h0000;
    else if (out_valid && !out_ready && (stall_q != 16'hFFFF))
      stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_noc_lfsr_inject_ctrl.sv
// Directed bench for noc_lfsr_inject_ctrl. Three instances share stimulus:
// a: MY_ID=0 PKT_LEN=4, b: MY_ID=2 PKT_LEN=4, c: MY_ID=1 PKT_LEN=1.
// Honours NOC_INJ_STALL_CNT_EN for the expected stall count.
module tb_noc_lfsr_inject_ctrl;

`ifdef NOC_INJ_STALL_CNT_EN
  localparam logic [15:0] STALL_EXP = 16'd5;
`else
  localparam logic [15:0] STALL_EXP = 16'd0;
`endif

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  cfg_rate;
  logic        cfg_seed_load;
  logic [3:0]  cfg_seed;
  logic        out_ready;

  logic        a_valid, b_valid, c_valid;
  logic [15:0] a_flit, b_flit, c_flit;
  logic        a_busy, b_busy, c_busy;
  logic [15:0] a_pkt, b_pkt, c_pkt;
  logic [3:0]  a_lfsr, b_lfsr, c_lfsr;
  logic [15:0] a_stall, b_stall, c_stall;

  int cmpCnt = 0;
  int errCnt = 0;

  logic [3:0] seqTab [15] = '{4'h0, 4'h1, 4'h2, 4'h5, 4'hA, 4'h4, 4'h9, 4'h3,
                              4'h6, 4'hD, 4'hB, 4'h7, 4'hE, 4'hC, 4'h8};

  noc_lfsr_inject_ctrl #(.MY_ID(0), .PKT_LEN(4)) u_a (
    .clk(clk), .rst(rst), .en(en), .cfg_rate(cfg_rate),
    .cfg_seed_load(cfg_seed_load), .cfg_seed(cfg_seed),
    .out_valid(a_valid), .out_ready(out_ready), .out_flit(a_flit),
    .busy(a_busy), .pkt_cnt(a_pkt), .lfsr_out(a_lfsr), .stall_cnt(a_stall)
  );

  noc_lfsr_inject_ctrl #(.MY_ID(2), .PKT_LEN(4)) u_b (
    .clk(clk), .rst(rst), .en(en), .cfg_rate(cfg_rate),
    .cfg_seed_load(cfg_seed_load), .cfg_seed(cfg_seed),
    .out_valid(b_valid), .out_ready(out_ready), .out_flit(b_flit),
    .busy(b_busy), .pkt_cnt(b_pkt), .lfsr_out(b_lfsr), .stall_cnt(b_stall)
  );

  noc_lfsr_inject_ctrl #(.MY_ID(1), .PKT_LEN(1)) u_c (
    .clk(clk), .rst(rst), .en(en), .cfg_rate(cfg_rate),
    .cfg_seed_load(cfg_seed_load), .cfg_seed(cfg_seed),
    .out_valid(c_valid), .out_ready(out_ready), .out_flit(c_flit),
    .busy(c_busy), .pkt_cnt(c_pkt), .lfsr_out(c_lfsr), .stall_cnt(c_stall)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    cmpCnt++;
    assert (obs === exp) else begin
      errCnt++;
      $error("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [3:0] rate, input logic rdy);
    en        = e;
    cfg_rate  = rate;
    out_ready = rdy;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Directed sequence of scenarios.
  initial begin
    rst = 1'b1;
    cfg_seed_load = 1'b0;
    cfg_seed = 4'h0;
    applyStimulus(1'b1, 4'hF, 1'b1);

    // Outputs held at zero while reset is asserted, even with injection enabled.
    tick();
    tick();
    checkOutput("rst_valid", 16'(a_valid), 16'h0);
    checkOutput("rst_busy", 16'(a_busy), 16'h0);
    checkOutput("rst_pkt", a_pkt, 16'h0);
    checkOutput("rst_lfsr", 16'(a_lfsr), 16'h0);
    checkOutput("rst_flit", a_flit, 16'h0);
    checkOutput("rst_stall", a_stall, 16'h0);

    // Rate 0 never injects; LFSR walks its full period.
    applyStimulus(1'b0, 4'h0, 1'b1);
    applyReset();
    en = 1'b1;
    checkOutput("lfsr_start", 16'(a_lfsr), 16'h0);
    for (int i = 1; i <= 30; i++) begin
      tick();
      checkOutput($sformatf("lfsr_seq%0d", i), 16'(a_lfsr), 16'(seqTab[i % 15]));
      checkOutput($sformatf("rate0_valid%0d", i), 16'(a_valid), 16'h0);
    end

    // Full-rate injection, FIFO always ready.
    applyStimulus(1'b0, 4'hF, 1'b1);
    applyReset();
    en = 1'b1;
    checkOutput("p2_busy0", 16'(a_busy), 16'h0);
    tick();
    checkOutput("p2_head", a_flit, 16'h7000);
    checkOutput("p2_head_v", 16'(a_valid), 16'h1);
    checkOutput("p2_busy1", 16'(a_busy), 16'h1);
    checkOutput("p2_b_head", b_flit, 16'h4800);
    checkOutput("p2_c_f0", c_flit, 16'hC400);
    checkOutput("p2_c_v0", 16'(c_valid), 16'h1);
    tick();
    checkOutput("p2_body1", a_flit, 16'h0400);
    checkOutput("p2_c_v1", 16'(c_valid), 16'h0);
    checkOutput("p2_c_pkt1", c_pkt, 16'h1);
    tick();
    checkOutput("p2_body2", a_flit, 16'h0800);
    checkOutput("p2_c_f1", c_flit, 16'hC401);
    tick();
    checkOutput("p2_tail", a_flit, 16'h8C00);
    checkOutput("p2_pkt_pre", a_pkt, 16'h0);
    checkOutput("p2_c_pkt2", c_pkt, 16'h2);
    tick();
    checkOutput("p2_gap_v", 16'(a_valid), 16'h0);
    checkOutput("p2_gap_busy", 16'(a_busy), 16'h0);
    checkOutput("p2_pkt1", a_pkt, 16'h1);
    checkOutput("p2_gap_lfsr", 16'(a_lfsr), 16'h4);
    checkOutput("p2_c_f2", c_flit, 16'hE402);
    tick();
    checkOutput("p2_head2", a_flit, 16'h5001);
    checkOutput("p2_head2_v", 16'(a_valid), 16'h1);
    checkOutput("p2_c_pkt3", c_pkt, 16'h3);

    // Backpressure on the head for five cycles.
    applyStimulus(1'b0, 4'hF, 1'b0);
    applyReset();
    en = 1'b1;
    tick();
    checkOutput("p3_head", a_flit, 16'h7000);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("p3_hold%0d", i), a_flit, 16'h7000);
      checkOutput($sformatf("p3_hold_v%0d", i), 16'(a_valid), 16'h1);
      checkOutput($sformatf("p3_busy%0d", i), 16'(a_busy), 16'h1);
    end
    checkOutput("p3_stall", a_stall, STALL_EXP);
    out_ready = 1'b1;
    tick();
    checkOutput("p3_body1", a_flit, 16'h0400);
    tick();
    checkOutput("p3_body2", a_flit, 16'h0800);
    tick();
    checkOutput("p3_tail", a_flit, 16'h8C00);
    tick();
    checkOutput("p3_pkt", a_pkt, 16'h1);
    checkOutput("p3_stall_end", a_stall, STALL_EXP);

    // Seed loading, including the forbidden all-ones seed.
    applyStimulus(1'b0, 4'h4, 1'b1);
    applyReset();
    cfg_seed = 4'h5;
    cfg_seed_load = 1'b1;
    tick();
    checkOutput("p4_seed5", 16'(a_lfsr), 16'h5);
    cfg_seed = 4'hF;
    tick();
    checkOutput("p4_seedF", 16'(a_lfsr), 16'h0);
    cfg_seed = 4'h9;
    tick();
    checkOutput("p4_seed9", 16'(a_lfsr), 16'h9);
    checkOutput("p4_nodec", 16'(b_busy), 16'h0);
    cfg_seed_load = 1'b0;
    en = 1'b1;
    tick();
    checkOutput("p4_lfsr3", 16'(a_lfsr), 16'h3);
    checkOutput("p4_b_idle", 16'(b_valid), 16'h0);
    tick();
    checkOutput("p4_lfsr6", 16'(a_lfsr), 16'h6);
    checkOutput("p4_b_head", b_flit, 16'h4800);
    checkOutput("p4_b_v", 16'(b_valid), 16'h1);

    // Enable dropped mid-packet, then reset during a body flit.
    applyStimulus(1'b0, 4'hF, 1'b1);
    applyReset();
    en = 1'b1;
    tick();
    checkOutput("p5_head", a_flit, 16'h7000);
    tick();
    checkOutput("p5_body1", a_flit, 16'h0400);
    en = 1'b0;
    tick();
    checkOutput("p5_body2", a_flit, 16'h0800);
    tick();
    checkOutput("p5_tail", a_flit, 16'h8C00);
    for (int i = 0; i < 7; i++) begin
      tick();
      checkOutput($sformatf("p5_quiet%0d", i), 16'(a_valid), 16'h0);
    end
    checkOutput("p5_pkt", a_pkt, 16'h1);
    checkOutput("p5_lfsr_hold", 16'(a_lfsr), 16'h2);
    en = 1'b1;
    tick();
    checkOutput("p5_head2", a_flit, 16'h7001);
    tick();
    checkOutput("p5_body2_1", a_flit, 16'h0401);
    rst = 1'b1;
    #1;
    checkOutput("p5_rst_v", 16'(a_valid), 16'h0);
    checkOutput("p5_rst_pkt", a_pkt, 16'h0);
    checkOutput("p5_rst_busy", 16'(a_busy), 16'h0);
    tick();
    rst = 1'b0;

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
    $finish;
  end

endmodule

// File: doc/noc_lfsr_inject_ctrl.md
Name: noc_lfsr_inject_ctrl

Overview:
- Per-node pseudo-random traffic injection controller for the 2x2 mesh.
- Holds the node's 4-bit XNOR LFSR and uses it to decide when to inject a packet and where to send it.
- Sequences each packet as PKT_LEN flits into the local input FIFO using a valid/ready handshake.
- Software configures the LFSR seed and the injection rate.

Parameters:
- MY_ID, 0, node id 0..3; used as the source field and for self-destination avoidance.
- PKT_LEN, 4, flits per packet, legal 1..16.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- en  in  1  injection enable; level-sensitive
- cfg_rate  in  4  injection threshold; inject when lfsr < cfg_rate
- cfg_seed_load  in  1  one-cycle pulse, loads cfg_seed into the LFSR
- cfg_seed  in  4  seed value
- out_valid  out  1  flit valid towards the FIFO write side
- out_ready  in  1  FIFO can accept (i.e. not full)
- out_flit  out  16  flit
- busy  out  1  packet in progress
- pkt_cnt  out  16  packets fully sent, wraps
- lfsr_out  out  4  current LFSR state (debug)
- stall_cnt  out  16  backpressure cycles (see Optional Feature)

Behaviour:
- Reset: rst asynchronous, active-high; clock clk. All outputs and state are 0 during and after reset; state is IDLE.
- LFSR:
  - 4 bits, feedback = ~(q[3]^q[0]), next = {q[2:0], fb}.
  - Advances every clk while en=1; holds while en=0.
  - Sequence from 0: 0,1,2,5,A,4,9,3,6,D,B,7,E,C,8,0 (period 15; F never reached).
  - cfg_seed_load has priority over advance (applies even with en=0). Loading F is forced to 0.
  - The LFSR keeps running during packets and stalls; packet fields are unaffected by it.
- FSM IDLE:
  - Decide when en=1 && lfsr_q < cfg_rate (pre-advance value). In that cycle:
    - dest = lfsr_q[3:2]; if dest==MY_ID then dest = MY_ID^2'b11.
    - Latch dest and seq = pkt_cnt[9:0].
    - Clear flit_idx; go to SEND.
  - cfg_rate=0 never injects.
- FSM SEND:
  - out_valid=1 starting the cycle after the decision (latency 1).
  - On out_valid && out_ready: flit_idx++. If flit_idx==PKT_LEN-1, go to IDLE and pkt_cnt++ in the same edge.
- Flit format, [15:14] type:
  - Type codes: 01 head, 00 body, 10 tail, 11 head+tail (PKT_LEN=1).
  - Head: [13:12] dest, [11:10] MY_ID, [9:0] seq.
  - Body/tail: [13:10] flit_idx, [9:0] seq.
- Handshake:
  - While out_valid && !out_ready, out_flit and flit_idx are held stable.
  - out_valid never drops before the flit is accepted.
- Back-to-back: after the tail is accepted, IDLE may decide in its first cycle. The minimum gap is therefore 1 idle cycle between packets.
- en=0 mid-packet: the current packet completes fully; no new decision is made.
- Seed load mid-packet: LFSR updates; the packet is unaffected.
- Reset mid-packet: out_valid drops immediately (asynchronous); the partial packet is abandoned and pkt_cnt returns to 0.
- busy = (state==SEND).

Optional Feature:
- Macro: NOC_INJ_STALL_CNT_EN.
- Defined: stall_cnt increments on each cycle with out_valid && !out_ready, saturates at 16'hFFFF, and clears only on reset.
- Undefined: the port remains and is driven 16'h0000; no counter logic is built.

Test Plan:
- Reset, en=1, cfg_rate=0, 30 cycles -> out_valid stays 0; lfsr_out follows 0,1,2,5,A,4,9,3,6,D,B,7,E,C,8,0,1...
- MY_ID=0, PKT_LEN=4, cfg_rate=F, out_ready=1, en rises in the first cycle after reset -> decision at lfsr=0, dest 00→11. Flits 16'h7000, 16'h0400, 16'h0800, 16'h8C00 on consecutive cycles; pkt_cnt=1 after the tail; the next head carries seq=1.
- Same setup, out_ready=0 for 5 cycles while the head is presented -> out_flit holds 16'h7000 and busy=1. With NOC_INJ_STALL_CNT_EN stall_cnt=5, otherwise 0. The remaining flits follow normally after out_ready=1.
- cfg_seed_load with seed F, en=0 -> lfsr_out=0 next cycle. Seed 9, then en=1 -> lfsr_out sequence 9,3,6. With cfg_rate=4 and MY_ID=2, the first decision is at lfsr=3 with dest=00.
- Drop en right after the head is accepted -> 3 remaining flits still sent, then out_valid=0 indefinitely. Assert rst during a body flit -> out_valid=0, pkt_cnt=0 immediately.
- PKT_LEN=1, MY_ID=1 -> every packet is a single flit, type 11, src 01; pkt_cnt increments per accepted flit.
